// File: rtl/dual_issue_if.sv
// Issue-stage bus between the IF/ID register, the hazard unit and the dual-issue
// scheduler.
//   master : the pipeline side. It drives the slot contents and the hazard requests,
//            and it receives the issue decisions and the statistics.
//   slave  : the scheduler. It receives the slot contents and the hazard requests,
//            and it drives the issue decisions and the statistics.
interface dual_issue_if #(parameter int CNT_W = 16);
  logic             s0_valid, s1_valid;
  logic [4:0]       s0_rs, s0_rt, s1_rs, s1_rt;
  logic [4:0]       s0_dst, s1_dst;
  logic             s0_regwrite, s1_regwrite;
  logic             s0_mem, s1_mem;
  logic             s0_branch, s1_branch;
  logic             hz_stall, hz_flush;
  logic             issue0, issue1;
  logic             lane0_sel;
  logic [1:0]       pc_adv;
  logic             ifid_hold;
  logic             split_state;
  logic [CNT_W-1:0] dual_cnt, single_cnt, split_cnt;

  modport master (
    output s0_valid, s1_valid, s0_rs, s0_rt, s1_rs, s1_rt, s0_dst, s1_dst,
           s0_regwrite, s1_regwrite, s0_mem, s1_mem, s0_branch, s1_branch,
           hz_stall, hz_flush,
    input  issue0, issue1, lane0_sel, pc_adv, ifid_hold, split_state,
           dual_cnt, single_cnt, split_cnt
  );

  modport slave (
    input  s0_valid, s1_valid, s0_rs, s0_rt, s1_rs, s1_rt, s0_dst, s1_dst,
           s0_regwrite, s1_regwrite, s0_mem, s1_mem, s0_branch, s1_branch,
           hz_stall, hz_flush,
    output issue0, issue1, lane0_sel, pc_adv, ifid_hold, split_state,
           dual_cnt, single_cnt, split_cnt
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// Issue-stage pairing controller. It decides whether the two IF/ID slots issue
// together or over two cycles. It applies the hazard unit's stall and flush, drives
// the PC advance and the IF/ID hold, and keeps saturating issue statistics.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; it also forces every output to zero
//   bus   : dual_issue_if slave. Inputs are the slot contents and hz_stall/hz_flush.
//           Outputs are issue0/1, lane0_sel, pc_adv, ifid_hold, split_state and
//           the counters.
//
// state | meaning
// PAIR  | normal pairing decision on the current IF/ID contents
// SPLIT | slot 0 already issued, slot 1 goes down lane 0 this cycle
module dual_issue_scheduler #(
  parameter int CNT_W = 16
) (
  input logic      clk,
  input logic      rst_n,
  dual_issue_if.slave bus
);

  typedef enum logic {PAIR = 1'b0, SPLIT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             conflict;
  logic             raw_hit, waw_hit, struct_hit, ctrl_hit;
  logic             inc_dual, inc_single, inc_split;
  logic [CNT_W-1:0] dual_q, single_q, split_q;

  // The slot-0 source registers never matter for pairing, because slot 0 is
  // always the older instruction.
  logic unused_inputs;
  assign unused_inputs = ^{bus.s0_rs, bus.s0_rt};

  assign raw_hit    = bus.s0_regwrite && (bus.s0_dst != 5'd0) &&
                      ((bus.s0_dst == bus.s1_rs) || (bus.s0_dst == bus.s1_rt));
  assign waw_hit    = bus.s0_regwrite && bus.s1_regwrite &&
                      (bus.s0_dst != 5'd0) && (bus.s0_dst == bus.s1_dst);
  assign struct_hit = bus.s0_mem && bus.s1_mem;
  assign ctrl_hit   = bus.s0_branch || (bus.s0_branch && bus.s1_branch);
  assign conflict   = bus.s0_valid && bus.s1_valid &&
                      (raw_hit || waw_hit || struct_hit || ctrl_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PAIR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.issue0    = 1'b0;
    bus.issue1    = 1'b0;
    bus.lane0_sel = 1'b0;
    bus.pc_adv    = 2'd0;
    bus.ifid_hold = 1'b0;
    inc_dual      = 1'b0;
    inc_single    = 1'b0;
    inc_split     = 1'b0;
    if (!rst_n) begin
      state_nxt = PAIR;
    end else if (bus.hz_flush) begin
      // The PC mux owns the redirect. The pending slot 1 of a split is dropped.
      state_nxt = PAIR;
    end else if (bus.hz_stall) begin
      bus.ifid_hold = 1'b1;
    end else begin
      case (state)
        PAIR: begin
          if (bus.s0_valid) begin
            bus.issue0 = 1'b1;
            if (!bus.s1_valid) begin
              bus.pc_adv = 2'd1;
              inc_single = 1'b1;
            end else if (conflict) begin
              bus.ifid_hold = 1'b1;
              state_nxt     = SPLIT;
              inc_split     = 1'b1;
            end else begin
              bus.issue1 = 1'b1;
              bus.pc_adv = 2'd2;
              inc_dual   = 1'b1;
            end
          end else begin
            // An invalid slot 0 means a bubble pair, so skip both slots.
            bus.pc_adv = 2'd2;
          end
        end
        SPLIT: begin
          bus.issue0    = 1'b1;
          bus.lane0_sel = 1'b1;
          bus.pc_adv    = 2'd2;
          state_nxt     = PAIR;
          inc_single    = 1'b1;
        end
        default: state_nxt = PAIR;
      endcase
    end
  end

  // The counters saturate at all-ones and never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dual_q   <= '0;
      single_q <= '0;
      split_q  <= '0;
    end else begin
      if (inc_dual   && (dual_q   != '1)) dual_q   <= dual_q   + CNT_W'(1);
      if (inc_single && (single_q != '1)) single_q <= single_q + CNT_W'(1);
      if (inc_split  && (split_q  != '1)) split_q  <= split_q  + CNT_W'(1);
    end
  end

  assign bus.split_state = rst_n && (state == SPLIT);
  assign bus.dual_cnt    = dual_q;
  assign bus.single_cnt  = single_q;
  assign bus.split_cnt   = split_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;

  logic clk;
  logic rst_n;

  dual_issue_if #(.CNT_W(4)) bif ();

  dual_issue_scheduler #(.CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       i0;
    logic       i1;
    logic       sel;
    logic [1:0] adv;
    logic       hold;
    logic       split;
    logic [3:0] dc;
    logic [3:0] sc;
    logic [3:0] spc;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  function automatic exp_t mk(logic i0, logic i1, logic sel, int adv, logic hold,
                              logic split, int dc, int sc, int spc);
    exp_t e;
    e.i0 = i0; e.i1 = i1; e.sel = sel; e.adv = 2'(adv); e.hold = hold;
    e.split = split; e.dc = 4'(dc); e.sc = 4'(sc); e.spc = 4'(spc);
    return e;
  endfunction

  // Monitor: on the falling edge, each queued expectation is checked against the
  // outputs the DUT presents in that cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      int   id;
      e = exp_q.pop_front();
      id = id_q.pop_front();
      a.i0 = bif.issue0; a.i1 = bif.issue1; a.sel = bif.lane0_sel;
      a.adv = bif.pc_adv; a.hold = bif.ifid_hold; a.split = bif.split_state;
      a.dc = bif.dual_cnt; a.sc = bif.single_cnt; a.spc = bif.split_cnt;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL step%0d: got i0=%b i1=%b sel=%b adv=%0d hold=%b split=%b dc=%0d sc=%0d spc=%0d expected i0=%b i1=%b sel=%b adv=%0d hold=%b split=%b dc=%0d sc=%0d spc=%0d",
                 id, a.i0, a.i1, a.sel, a.adv, a.hold, a.split, a.dc, a.sc, a.spc,
                 e.i0, e.i1, e.sel, e.adv, e.hold, e.split, e.dc, e.sc, e.spc);
      end
    end
  end

  task automatic cyc(input exp_t e);
    exp_q.push_back(e);
    id_q.push_back(step_no);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bif.s0_valid = 0; bif.s1_valid = 0;
    bif.s0_rs = 0; bif.s0_rt = 0; bif.s1_rs = 0; bif.s1_rt = 0;
    bif.s0_dst = 0; bif.s1_dst = 0;
    bif.s0_regwrite = 0; bif.s1_regwrite = 0;
    bif.s0_mem = 0; bif.s1_mem = 0; bif.s0_branch = 0; bif.s1_branch = 0;
    bif.hz_stall = 0; bif.hz_flush = 0;
  endtask

  // Independent pair: s0 writes r3, s1 reads r4/r5 and writes r6.
  task automatic indep();
    clr();
    bif.s0_valid = 1; bif.s1_valid = 1;
    bif.s0_dst = 5'd3; bif.s0_regwrite = 1;
    bif.s1_rs = 5'd4; bif.s1_rt = 5'd5; bif.s1_dst = 5'd6; bif.s1_regwrite = 1;
  endtask

  // RAW pair: s0 writes r5, s1 reads r5.
  task automatic raw_pair();
    clr();
    bif.s0_valid = 1; bif.s1_valid = 1;
    bif.s0_dst = 5'd5; bif.s0_regwrite = 1;
    bif.s1_rs = 5'd5; bif.s1_rt = 5'd1; bif.s1_dst = 5'd2; bif.s1_regwrite = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst_n = 0;
    @(posedge clk); #1;

    // Reset: outputs are gated even with a live pair presented.
    indep();     cyc(mk(0,0,0,0,0,0, 0,0,0));
    raw_pair();  cyc(mk(0,0,0,0,0,0, 0,0,0));
    rst_n = 1;

    // Independent pair issues on both lanes.
    indep();     cyc(mk(1,1,0,2,0,0, 0,0,0));
    // RAW pair splits over two cycles.
    raw_pair();  cyc(mk(1,0,0,0,1,0, 1,0,0));
    cyc(mk(1,0,1,2,0,1, 1,0,1));
    // A RAW dependency on r0 is not a conflict.
    clr();
    bif.s0_valid = 1; bif.s1_valid = 1; bif.s0_dst = 0; bif.s0_regwrite = 1;
    bif.s1_rs = 0; bif.s1_rt = 0; bif.s1_dst = 5'd7; bif.s1_regwrite = 1;
    cyc(mk(1,1,0,2,0,0, 1,1,1));
    // Two memory operations split, then a 3-cycle stall lands inside SPLIT.
    clr();
    bif.s0_valid = 1; bif.s1_valid = 1; bif.s0_mem = 1; bif.s1_mem = 1;
    bif.s0_dst = 5'd1; bif.s0_regwrite = 1; bif.s1_rs = 5'd2; bif.s1_rt = 5'd3;
    bif.s1_dst = 5'd4; bif.s1_regwrite = 1;
    cyc(mk(1,0,0,0,1,0, 2,1,1));
    bif.hz_stall = 1;
    for (int k = 0; k < 3; k++) cyc(mk(0,0,0,0,1,1, 2,1,2));
    bif.hz_stall = 0;
    cyc(mk(1,0,1,2,0,1, 2,1,2));
    // WAW pair splits, then a flush together with a stall drops the pending slot 1.
    clr();
    bif.s0_valid = 1; bif.s1_valid = 1; bif.s0_dst = 5'd8; bif.s0_regwrite = 1;
    bif.s1_dst = 5'd8; bif.s1_regwrite = 1; bif.s1_rs = 5'd1; bif.s1_rt = 5'd2;
    cyc(mk(1,0,0,0,1,0, 2,2,2));
    bif.hz_flush = 1; bif.hz_stall = 1;
    cyc(mk(0,0,0,0,0,1, 2,2,3));
    // Back in PAIR with split_cnt unchanged. Only slot 0 is valid.
    clr();
    bif.s0_valid = 1; bif.s0_dst = 5'd9; bif.s0_regwrite = 1;
    cyc(mk(1,0,0,1,0,0, 2,2,3));
    // A branch in slot 0 forces a split.
    clr();
    bif.s0_valid = 1; bif.s1_valid = 1; bif.s0_branch = 1;
    bif.s1_rs = 5'd10; bif.s1_rt = 5'd11; bif.s1_dst = 5'd12; bif.s1_regwrite = 1;
    cyc(mk(1,0,0,0,1,0, 2,3,3));
    cyc(mk(1,0,1,2,0,1, 2,3,4));
    // A bubble in slot 0 is skipped without issue.
    clr();
    bif.s1_valid = 1;
    cyc(mk(0,0,0,2,0,0, 2,4,4));
    // A flush in PAIR suppresses an otherwise dual-issuable pair.
    indep(); bif.hz_flush = 1;
    cyc(mk(0,0,0,0,0,0, 2,4,4));
    // Saturation: 20 dual pairs hold dual_cnt at 15.
    indep();
    for (int k = 0; k < 20; k++) cyc(mk(1,1,0,2,0,0, (2+k > 15) ? 15 : 2+k, 4,4));
    // Enter SPLIT, then reset mid-split.
    raw_pair();  cyc(mk(1,0,0,0,1,0, 15,4,4));
    rst_n = 0;
    cyc(mk(0,0,0,0,0,0, 0,0,0));
    cyc(mk(0,0,0,0,0,0, 0,0,0));
    rst_n = 1;
    // The FSM is back in PAIR, so the RAW pair starts a fresh split.
    cyc(mk(1,0,0,0,1,0, 0,0,0));
    cyc(mk(1,0,1,2,0,1, 0,0,1));
    clr();

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

Issue-stage pairing controller for the dual-issue pipeline. Each cycle it inspects the two instructions in IF/ID (slot 0 older, slot 1 younger) and decides whether both lanes issue into ID/EX together, or whether the pair is split over two cycles. It sequences the split with a two-state FSM, applies the hazard unit's stall/flush, and drives PC advance and the IF/ID hold. Saturating counters record issue statistics.

## Interface
- CNT_W, 16, width of each statistics counter

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s0_valid, s1_valid  in  1  slot holds a real instruction
- s0_rs, s0_rt, s1_rs, s1_rt  in  5  source register numbers
- s0_dst, s1_dst  in  5  destination register numbers
- s0_regwrite, s1_regwrite  in  1  slot writes s*_dst
- s0_mem, s1_mem  in  1  slot is a load or store
- s0_branch, s1_branch  in  1  slot is a branch or jump
- hz_stall  in  1  load-use stall from the hazard detection unit
- hz_flush  in  1  mispredict/redirect flush from the hazard detection unit
- issue0, issue1  out  1  lane 0 / lane 1 of ID/EX receives a valid instruction
- lane0_sel  out  1  source for lane 0: 0 = slot 0, 1 = slot 1
- pc_adv  out  2  PC increment in instructions (0, 1 or 2)
- ifid_hold  out  1  IF/ID keeps its contents
- split_state  out  1  FSM is in SPLIT
- dual_cnt, single_cnt, split_cnt  out  CNT_W  statistics

## Operation
- FSM states: PAIR (reset) and SPLIT.
- Conflict (evaluated only when s0_valid & s1_valid) is true when any of these hold:
  - RAW: s0_regwrite, s0_dst≠0, and s0_dst equals s1_rs or s1_rt.
  - WAW: both regwrite, s0_dst=s1_dst≠0.
  - Structural: s0_mem & s1_mem, because there is a single data-memory port.
  - Control: s0_branch or (s0_branch & s1_branch).
- Priority: hz_flush > hz_stall > normal.
- hz_flush: issue0=issue1=0, pc_adv=0, ifid_hold=0, next state PAIR. The fetch redirect is owned by the PC mux.
- hz_stall without hz_flush: issue0=issue1=0, pc_adv=0, ifid_hold=1, state unchanged.
- PAIR, normal cycle:
  - Both valid, no conflict: issue0=issue1=1, lane0_sel=0, pc_adv=2. dual_cnt increments.
  - Both valid, conflict: issue0=1, issue1=0, lane0_sel=0, pc_adv=0, ifid_hold=1, next state SPLIT. split_cnt increments.
  - s0 valid only: issue0=1, pc_adv=1. single_cnt increments.
  - s0 invalid: no issue, pc_adv=2, so the bubble pair is skipped.
- SPLIT, normal cycle: issue0=1, lane0_sel=1 (slot 1 goes down lane 0), issue1=0, pc_adv=2, ifid_hold=0, next state PAIR. single_cnt increments.
- Counters saturate at all-ones and never wrap. They only count cycles with at least one issue.
- All non-counter outputs are combinational from state and inputs.

## Timing
- Issue decisions take zero cycles. The state and counters update on the rising edge of clk.
- A split pair occupies exactly 2 non-stalled cycles. Each stall cycle extends it by one cycle.
- While rst_n is low: state=PAIR, all counters=0, issue0=issue1=0, pc_adv=0, ifid_hold=0, lane0_sel=0, split_state=0. Outputs are gated by rst_n.
- Reset asserted while in SPLIT abandons the pending slot 1 and returns to PAIR.
- hz_flush and hz_stall asserted together: the flush behaviour applies.
- Flush while in SPLIT: the pending slot-1 instruction is never issued.

## Test plan
- Independent pair (s0: dst r3, s1: rs r4/rt r5, regwrite both, no mem/branch) -> issue0=issue1=1, pc_adv=2. dual_cnt goes 0→1.
- RAW pair (s0 writes r5, s1_rs=r5):
  - cycle 0: issue0=1, issue1=0, ifid_hold=1, pc_adv=0.
  - cycle 1: split_state=1, issue0=1, lane0_sel=1, pc_adv=2.
  - cycle 2: PAIR. split_cnt=1, single_cnt=1.
- RAW on r0 (s0_dst=0, s1_rs=0) -> no conflict, dual issue, pc_adv=2. Separately, both s*_mem=1 -> split.
- Enter SPLIT, then hz_stall for 3 cycles -> each stall cycle has issue0=0, ifid_hold=1, split_state=1. The cycle after the stall drops issues slot 1 with pc_adv=2.
- Enter SPLIT, then hz_flush=1 together with hz_stall=1 -> no issue, pc_adv=0, next cycle split_state=0. split_cnt unchanged by the flush.
- With CNT_W=4, issue 20 dual pairs -> dual_cnt holds at 15. Then pulse rst_n low mid-SPLIT -> all counters 0, state PAIR, issue outputs 0 while rst_n is low.
